mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the single-port unified memory between the instruction-fetch path and the data path (LDUR/STUR, driven by the decoder's MemReadEn/MemWrite). It accepts level-held requests from both sides, issues one memory transaction at a time through a ready-based memory handshake, and returns read data with a one-cycle ack pulse. Data accesses have priority, and a starvation counter guarantees fetch progress. It sits between the pipeline front/back ends and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the memory.
//   Fetch side : i_req, i_addr  -> arbiter ; i_ack, i_rdata -> fetch
//   Data side  : d_req, d_we, d_addr, d_wdata -> arbiter ; d_ack, d_rdata -> data path
//   Memory side: mem_req, mem_we, mem_addr, mem_wdata -> memory ; mem_rdata, mem_ready -> arbiter
// Modport master is the arbiter's view (it masters the memory transaction);
// modport slave is the surrounding environment (requesters plus memory model).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data path.
// One transaction at a time; data has priority, but after STARVE_MAX
// consecutive data grants with fetch waiting, fetch wins the next arbitration.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-high reset
//   bus   - mem_port_arbiter_if.master (fetch, data and memory handshakes)
//   busy  - high whenever the sequencer is not idle
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output logic                busy
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;

  state_t            state, state_nx;
  logic              grant_i, grant_d, mem_done;
  logic              owner_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic [CW-1:0]     starve;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    mem_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && !(bus.i_req && starve == STARVE_LIM)) begin
          grant_d  = 1'b1;
          state_nx = D_ACC;
        end else if (bus.i_req) begin
          grant_i  = 1'b1;
          state_nx = I_ACC;
        end
      end
      I_ACC, D_ACC: begin
        if (bus.mem_ready) begin
          mem_done = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are captured at grant so requesters may change or drop
  // their inputs while the access is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_d   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      starve    <= '0;
    end else begin
      if (grant_d) begin
        owner_d <= 1'b1;
        we_q    <= bus.d_we;
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        if (!bus.i_req)              starve <= '0;
        else if (starve != STARVE_LIM) starve <= starve + 1'b1;
      end
      if (grant_i) begin
        owner_d <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= bus.i_addr;
        starve  <= '0;
      end
      if (mem_done) begin
        if (state == I_ACC)  i_rdata_q <= bus.mem_rdata;
        else if (!we_q)      d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Handshake outputs decode from state so that reset removes them at once.
  assign bus.mem_req   = (state == I_ACC) || (state == D_ACC);
  assign bus.mem_we    = (state == D_ACC) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ack     = (state == RESP) && !owner_d;
  assign bus.d_ack     = (state == RESP) && owner_d;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic is_d; logic [63:0] rdata; } ack_t;
  typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; } mem_t;
  typedef struct { logic we; logic pulse; logic [63:0] addr; logic [63:0] wdata; } dreq_t;

  ack_t        exp_ack[$];
  mem_t        exp_mem[$];
  logic [63:0] i_pend[$];
  dreq_t       d_pend[$];
  logic [63:0] mem_store [logic [63:0]];

  int          vectors     = 0;
  int          miscompares = 0;
  int          lat         = 0;
  int          mem_wait    = 0;
  bit          i_hold_off  = 1'b0;
  logic [63:0] d_rdata_model = '0;
  ack_t        a_exp;
  mem_t        m_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_peek(input logic [63:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return a ^ 64'h5A5A_0000_0000_0000;
  endfunction

  // Memory model: completes each request after lat wait cycles, checks the
  // transaction fields against the expected-transaction queue.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (reset || !bus.mem_req) mem_wait = 0;
      else if (mem_wait < lat) mem_wait++;
      else begin
        mem_wait      = 0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = bus.mem_we ? 64'hBAD0_BAD0_BAD0_BAD0 : mem_peek(bus.mem_addr);
        if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
        if (exp_mem.size() == 0) check("mem_extra", 64'(exp_mem.size()), 64'd1);
        else begin
          m_exp = exp_mem.pop_front();
          check("mem_we", 64'(bus.mem_we), 64'(m_exp.we));
          check("mem_addr", bus.mem_addr, m_exp.addr);
          if (m_exp.we) check("mem_wdata", bus.mem_wdata, m_exp.wdata);
        end
      end
    end
  end

  // Ack monitor: pops the expected completion order and read data.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        check("ack_onehot", 64'(bus.i_ack & bus.d_ack), 64'd0);
        if (exp_ack.size() == 0) check("ack_extra", 64'(exp_ack.size()), 64'd1);
        else begin
          a_exp = exp_ack.pop_front();
          check("ack_owner", 64'(bus.d_ack), 64'(a_exp.is_d));
          if (a_exp.is_d) check("d_rdata", bus.d_rdata, a_exp.rdata);
          else            check("i_rdata", bus.i_rdata, a_exp.rdata);
        end
      end
    end
  end

  // Fetch requester: holds i_req with the front address until its ack.
  initial begin
    bus.i_req  = 1'b0;
    bus.i_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.i_req && bus.i_ack && i_pend.size() > 0) void'(i_pend.pop_front());
      if (i_pend.size() > 0 && !i_hold_off) begin
        bus.i_req  = 1'b1;
        bus.i_addr = i_pend[0];
      end else bus.i_req = 1'b0;
    end
  end

  // Data requester: held entries drop on ack, pulse entries after one cycle.
  initial begin
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    forever begin
      @(negedge clk);
      if (bus.d_req && d_pend.size() > 0 && (bus.d_ack || d_pend[0].pulse))
        void'(d_pend.pop_front());
      if (d_pend.size() > 0) begin
        bus.d_req   = 1'b1;
        bus.d_we    = d_pend[0].we;
        bus.d_addr  = d_pend[0].addr;
        bus.d_wdata = d_pend[0].wdata;
      end else bus.d_req = 1'b0;
    end
  end

  task automatic push_load(input logic [63:0] a);
    d_pend.push_back(dreq_t'{1'b0, 1'b0, a, 64'h0});
  endtask

  task automatic expect_load(input logic [63:0] a);
    exp_mem.push_back(mem_t'{1'b0, a, 64'h0});
    d_rdata_model = mem_peek(a);
    exp_ack.push_back(ack_t'{1'b1, d_rdata_model});
  endtask

  task automatic expect_fetch(input logic [63:0] a);
    exp_mem.push_back(mem_t'{1'b0, a, 64'h0});
    exp_ack.push_back(ack_t'{1'b0, mem_peek(a)});
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((exp_ack.size() + exp_mem.size() + i_pend.size() + d_pend.size() != 0 || busy)
           && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, 64'(exp_ack.size() + exp_mem.size() + i_pend.size() + d_pend.size() + int'(busy)),
          64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",   64'(bus.mem_req), 64'd0);
    check("rst_mem_we",    64'(bus.mem_we), 64'd0);
    check("rst_i_ack",     64'(bus.i_ack), 64'd0);
    check("rst_d_ack",     64'(bus.d_ack), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_mem_addr",  bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    check("rst_i_rdata",   bus.i_rdata, 64'd0);
    check("rst_d_rdata",   bus.d_rdata, 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Single fetch, zero-latency memory
    lat = 0;
    mem_store[64'h40] = 64'hDEAD;
    i_pend.push_back(64'h40);
    expect_fetch(64'h40);
    @(posedge clk); #1;
    check("t1_mem_req",  64'(bus.mem_req), 64'd1);
    check("t1_mem_addr", bus.mem_addr, 64'h40);
    check("t1_mem_we",   64'(bus.mem_we), 64'd0);
    @(posedge clk); #1;
    check("t1_i_ack",    64'(bus.i_ack), 64'd1);
    check("t1_i_rdata",  bus.i_rdata, 64'hDEAD);
    @(posedge clk); #1;
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_ack_low",  64'(bus.i_ack), 64'd0);
    drain("t1_drain");

    // Store with 4 wait cycles: mem_req must stay up for 5 cycles
    lat = 4;
    d_pend.push_back(dreq_t'{1'b1, 1'b0, 64'h100, 64'h55});
    exp_mem.push_back(mem_t'{1'b1, 64'h100, 64'h55});
    exp_ack.push_back(ack_t'{1'b1, d_rdata_model});
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        if (n == 0) check("t2_mem_we", 64'(bus.mem_we), 64'd1);
        n++;
      end
      if (bus.d_ack) seen = 1'b1;
    end
    check("t2_mem_req_cycles", 64'(n), 64'd5);
    check("t2_ack_seen", 64'(seen), 64'd1);
    drain("t2_drain");

    // Both requesters held: D,D,D,I,D,D,D,I
    lat = 1;
    for (int k = 0; k < 6; k++) push_load(64'h200 + 64'(8 * k));
    for (int k = 0; k < 2; k++) i_pend.push_back(64'h1000 + 64'(8 * k));
    begin
      int di = 0;
      int ii = 0;
      for (int g = 0; g < 8; g++) begin
        if (g % 4 == 3) begin expect_fetch(64'h1000 + 64'(8 * ii)); ii++; end
        else begin expect_load(64'h200 + 64'(8 * di)); di++; end
      end
    end
    drain("t3_drain");

    // Third D grant made with fetch withdrawn clears the starve count
    lat = 0;
    for (int k = 0; k < 6; k++) push_load(64'h300 + 64'(8 * k));
    i_pend.push_back(64'h2000);
    for (int k = 0; k < 6; k++) expect_load(64'h300 + 64'(8 * k));
    expect_fetch(64'h2000);
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(posedge clk); #1;
      if (bus.d_ack) n++;
    end
    check("t4_two_d_acks", 64'(n), 64'd2);
    i_hold_off = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_third_d_addr", bus.mem_addr, 64'h310);
    i_hold_off = 1'b0;
    drain("t4_drain");

    // One-cycle load request still completes exactly once
    lat = 2;
    mem_store[64'h400] = 64'h77;
    d_pend.push_back(dreq_t'{1'b0, 1'b1, 64'h400, 64'h0});
    expect_load(64'h400);
    drain("t5_drain");
    repeat (4) begin @(posedge clk); #1; end
    check("t5_idle",    64'(busy), 64'd0);
    check("t5_d_rdata", bus.d_rdata, 64'h77);

    // Asynchronous reset in the middle of a data access
    lat = 50;
    push_load(64'h500);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_pre_mem_req", 64'(bus.mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_mem_req", 64'(bus.mem_req), 64'd0);
    check("t6_busy",    64'(busy), 64'd0);
    check("t6_d_ack",   64'(bus.d_ack), 64'd0);
    check("t6_d_rdata", bus.d_rdata, 64'd0);
    d_pend.delete();
    lat = 0;
    i_pend.push_back(64'h600);
    expect_fetch(64'h600);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
